multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore/Mealy control FSM that sequences the multicycle datapath: register file, memory port, PC and ALU.
- Issues the 3-bit ALUOp select consumed by the ALU's 8:1 result mux on every cycle.
- Steps each instruction through FETCH, DECODE and EXECUTE/MEM/WRITEBACK states.
- Stalls on a memory ready handshake and bounds every memory wait with a timeout counter.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles waiting on mem_ready before bus_error; range 1..255.
- TO_W, 8: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; 1 = keep fetching instructions
- opcode  in  6  IR[31:26], stable from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory has completed the current access this cycle
- ALUOp  out  3  ALU result select: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- PCWrite  out  1
- PCWriteCond  out  1
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- IorD  out  1
- MemRead  out  1
- MemWrite  out  1
- IRWrite  out  1
- RegWrite  out  1
- RegDst  out  1
- MemtoReg  out  1
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- bus_error  out  1  one-cycle pulse on a memory timeout
- state_out  out  4  current state code, for debug

Behaviour:
- Reset:
  - rst_n=0 forces state IDLE(0) and clears the wait counter, asynchronously.
  - All outputs are 0 in IDLE, including ALUOp=000.
  - Reset mid-instruction abandons the instruction; no retire pulse is issued.
- Signals not listed for a state are 0.
- State table, with state codes:
  - IDLE(0): run=1 -> FETCH.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
    - IRWrite and PCWrite are asserted only in the cycle mem_ready=1 (Mealy).
    - Then -> DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOp=ADD. Next state by opcode:
    - 0x23 or 0x2B -> MEMADDR
    - 0x00 with supported funct -> EXEC_R
    - 0x08 -> EXEC_I
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - anything else -> ILLEGAL
  - Supported funct: 0x24 AND, 0x25 OR, 0x20 ADD, 0x26 XOR, 0x27 NOR, 0x22 SUB, 0x2A SLT.
  - MEMADDR(3): ALUSrcA=1, ALUSrcB=10, ADD. Then -> MEMRD if opcode=0x23, else -> MEMWR.
  - MEMRD(4): MemRead=1, IorD=1. Waits on mem_ready, then -> MEM_WB.
  - MEM_WB(5): RegWrite=1, MemtoReg=1, RegDst=0. Retires.
  - MEMWR(6): MemWrite=1, IorD=1. Retires in the cycle mem_ready=1.
  - EXEC_R(7): ALUSrcA=1, ALUSrcB=00, ALUOp=decode(funct). Then -> R_WB.
  - R_WB(8): RegWrite=1, RegDst=1. Retires.
  - EXEC_I(9): ALUSrcA=1, ALUSrcB=10, ADD. Then -> I_WB.
  - I_WB(10): RegWrite=1, RegDst=0. Retires.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01. Retires.
  - JUMP(12): PCWrite=1, PCSource=10. Retires.
  - ILLEGAL(13): illegal=1 for one cycle, then -> IDLE regardless of run.
  - TIMEOUT(14): bus_error=1 for one cycle, then -> IDLE.
- Retire means:
  - instr_done=1 that cycle.
  - Next state is FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the instruction completes; run is sampled only at retire and in IDLE.
- Memory waits (FETCH, MEMRD, MEMWR):
  - Wait counter clears on entry and increments each cycle mem_ready=0.
  - MemRead/MemWrite, IorD and ALU controls are held stable while waiting.
  - Counter reaching MEM_TIMEOUT with mem_ready=0 -> TIMEOUT.
  - mem_ready=1 in the same cycle the count would hit MEM_TIMEOUT: the access completes; no timeout.
- mem_ready outside a memory state is ignored.
- Latencies, from FETCH entry with zero wait:
  - R-type 4 cycles, ADDI 4, LW 5, SW 4, BEQ 3, J 3.
- Unused state code 15: recovers to IDLE next cycle; all outputs 0.

Decomposition:
- Package mc_pkg holds:
  - state enum, 4 bits
  - ALUOp codes
  - opcode constants: R 0x00, LW 0x23, SW 0x2B, ADDI 0x08, BEQ 0x04, J 0x02
  - funct constants
  - ALUSrcB and PCSource encodings
- One sub-module, alu_op_decode: combinational funct[5:0] -> {ALUOp[2:0], funct_valid}. Used in both DECODE and EXEC_R.

Test Plan:
- Reset, then run=1 with mem_ready held 1 and opcode 0x00/funct 0x22 -> state sequence 1,2,7,8.
  - ALUOp=110 in state 7; RegWrite=RegDst=1 in state 8; instr_done pulse; state back to 1.
- LW 0x23 with mem_ready=0 for 3 cycles in MEMRD -> MemRead=IorD=1 held 4 cycles, then MEM_WB with MemtoReg=1.
  - Total 8 cycles from FETCH entry.
- SW with mem_ready stuck at 0, MEM_TIMEOUT=15 -> MEMWR for 15 cycles, then TIMEOUT with bus_error=1 for 1 cycle, then IDLE.
  - Repeat with mem_ready=1 on the 15th cycle -> retire; no bus_error.
- opcode 0x3F, then opcode 0x00/funct 0x08 -> illegal pulse 1 cycle after DECODE, then IDLE; instr_done never asserted.
- BEQ then J, with run dropped during BEQ's DECODE:
  - BEQ: ALUOp=110, PCWriteCond=1, PCSource=01, retires.
  - FSM then goes to IDLE and J is not fetched.
  - Raise run again -> J retires with PCSource=10, PCWrite=1.
- rst_n pulled low asynchronously mid-MEMRD -> state_out=0 and all outputs 0 immediately, without a clock edge.
  - Release -> waits in IDLE until run=1.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM.
// States, ALU selects, opcodes, funct codes and mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEM_WB  = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC_R  = 4'd7,
    S_R_WB    = 4'd8,
    S_EXEC_I  = 4'd9,
    S_I_WB    = 4'd10,
    S_BRANCH  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13,
    S_TIMEOUT = 4'd14
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_XOR = 6'h26;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct decoder: ALU select plus a supported-funct flag.
// Shared by DECODE (legality) and EXEC_R (ALU select).
module alu_op_decode
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_AND;
    funct_valid = 1'b1;
    unique case (1'b1)
      (funct == F_AND): alu_op = ALU_AND;
      (funct == F_OR):  alu_op = ALU_OR;
      (funct == F_ADD): alu_op = ALU_ADD;
      (funct == F_XOR): alu_op = ALU_XOR;
      (funct == F_NOR): alu_op = ALU_NOR;
      (funct == F_SUB): alu_op = ALU_SUB;
      (funct == F_SLT): alu_op = ALU_SLT;
      default:          funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM with bounded memory waits.
// Outputs are decoded from state, plus mem_ready in memory states.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic [2:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       instr_done,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state_out
);

  state_t          state;
  state_t          next;
  logic [TO_W-1:0] wait_cnt;
  logic [2:0]      r_alu_op;
  logic            f_ok;
  logic            timed_out;

  alu_op_decode u_dec (
    .funct       (funct),
    .alu_op      (r_alu_op),
    .funct_valid (f_ok)
  );

  // Expires on the wait cycle that would bring the count to the limit.
  assign timed_out = !mem_ready &&
    (wait_cnt == TO_W'(MEM_TIMEOUT - 1));

  assign state_out = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next;
      if (next != state)
        wait_cnt <= '0;
      else if (!mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    next        = state;
    ALUOp       = ALU_AND;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = PCS_ALU;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    instr_done  = 1'b0;
    illegal     = 1'b0;
    bus_error   = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) next = S_FETCH;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_4;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next    = S_DECODE;
        end else if (timed_out) begin
          next = S_TIMEOUT;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        ALUOp   = ALU_ADD;
        unique case (1'b1)
          (opcode == OP_LW),
          (opcode == OP_SW):      next = S_MEMADDR;
          (opcode == OP_R):       next = f_ok ? S_EXEC_R : S_ILLEGAL;
          (opcode == OP_ADDI):    next = S_EXEC_I;
          (opcode == OP_BEQ):     next = S_BRANCH;
          (opcode == OP_J):       next = S_JUMP;
          default:                next = S_ILLEGAL;
        endcase
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        next    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready)      next = S_MEM_WB;
        else if (timed_out) next = S_TIMEOUT;
      end
      S_MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        next       = run ? S_FETCH : S_IDLE;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next       = run ? S_FETCH : S_IDLE;
        end else if (timed_out) begin
          next = S_TIMEOUT;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_B;
        ALUOp   = r_alu_op;
        next    = S_R_WB;
      end
      S_R_WB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
        next       = run ? S_FETCH : S_IDLE;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        next    = S_I_WB;
      end
      S_I_WB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next       = run ? S_FETCH : S_IDLE;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_B;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCS_ALUOUT;
        instr_done  = 1'b1;
        next        = run ? S_FETCH : S_IDLE;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCS_JUMP;
        instr_done = 1'b1;
        next       = run ? S_FETCH : S_IDLE;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        next    = S_IDLE;
      end
      S_TIMEOUT: begin
        bus_error = 1'b1;
        next      = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected traces vs the FSM.
// Directed scenarios, randomized instruction mix, async reset.
module tb_multicycle_control;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic [2:0] ALUOp;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       PCWrite;
  logic       PCWriteCond;
  logic [1:0] PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       instr_done;
  logic       illegal;
  logic       bus_error;
  logic [3:0] state_out;

  typedef struct packed {
    logic [2:0] aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rgw;
    logic       rgd;
    logic       m2r;
    logic       done;
    logic       ill;
    logic       berr;
  } ctl_t;

  typedef struct {
    int         st;
    ctl_t       c;
    logic       mr;
    logic       rn;
    logic [5:0] op;
    logic [5:0] fn;
  } step_t;

  step_t      q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic       in_idle;
  int         step_no = 0;
  ctl_t       obs_c;

  assign obs_c = {ALUOp, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond,
                  PCSource, IorD, MemRead, MemWrite, IRWrite,
                  RegWrite, RegDst, MemtoReg, instr_done,
                  illegal, bus_error};

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .ALUOp       (ALUOp),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .MemtoReg    (MemtoReg),
    .instr_done  (instr_done),
    .illegal     (illegal),
    .bus_error   (bus_error),
    .state_out   (state_out)
  );

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // {valid, ALU select} for an R-type funct, straight from the op table.
  function automatic logic [3:0] fn_alu(input logic [5:0] f);
    case (f)
      6'h24:   return 4'b1_000;
      6'h25:   return 4'b1_001;
      6'h20:   return 4'b1_010;
      6'h26:   return 4'b1_011;
      6'h27:   return 4'b1_100;
      6'h22:   return 4'b1_110;
      6'h2A:   return 4'b1_111;
      default: return 4'b0_000;
    endcase
  endfunction

  task automatic push(input int st, input ctl_t c, input logic mr,
                      input logic rn, input logic [5:0] op,
                      input logic [5:0] fn);
    step_t s;
    s.st = st; s.c = c; s.mr = mr; s.rn = rn; s.op = op; s.fn = fn;
    q.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      push(0, '0, 1'($urandom), 1'b0, 6'($urandom), 6'($urandom));
  endtask

  // Expected cycle-by-cycle trace of one instruction.
  // wf/wm: wait cycles before mem_ready in fetch / data access.
  task automatic gen(input logic [5:0] op, input logic [5:0] fn,
                     input int wf, input int wm, input logic r);
    ctl_t       c;
    ctl_t       m;
    logic [3:0] fa;
    logic       lw;
    int         st;
    if (in_idle)
      push(0, '0, 1'($urandom), 1'b1, op, fn);
    c = '0; c.mrd = 1; c.srcb = 2'b01; c.aluop = 3'b010;
    for (int i = 0; i < wf && i < TMO; i++)
      push(1, c, 1'b0, r, op, fn);
    if (wf >= TMO) begin
      c = '0; c.berr = 1;
      push(14, c, 1'($urandom), r, op, fn);
      in_idle = 1'b1;
      return;
    end
    c.irw = 1; c.pcw = 1;
    push(1, c, 1'b1, r, op, fn);
    c = '0; c.srcb = 2'b11; c.aluop = 3'b010;
    push(2, c, 1'($urandom), r, op, fn);
    fa = fn_alu(fn);
    c = '0;
    if (op == 6'h00 && fa[3]) begin
      c.srca = 1; c.aluop = fa[2:0];
      push(7, c, 1'($urandom), r, op, fn);
      c = '0; c.rgw = 1; c.rgd = 1; c.done = 1;
      push(8, c, 1'($urandom), r, op, fn);
      in_idle = !r;
    end else if (op == 6'h23 || op == 6'h2B) begin
      lw = (op == 6'h23);
      c.srca = 1; c.srcb = 2'b10; c.aluop = 3'b010;
      push(3, c, 1'($urandom), r, op, fn);
      m = '0; m.iord = 1;
      if (lw) m.mrd = 1; else m.mwr = 1;
      st = lw ? 4 : 6;
      for (int i = 0; i < wm && i < TMO; i++)
        push(st, m, 1'b0, r, op, fn);
      if (wm >= TMO) begin
        c = '0; c.berr = 1;
        push(14, c, 1'($urandom), r, op, fn);
        in_idle = 1'b1;
        return;
      end
      if (lw) begin
        push(4, m, 1'b1, r, op, fn);
        c = '0; c.rgw = 1; c.m2r = 1; c.done = 1;
        push(5, c, 1'($urandom), r, op, fn);
      end else begin
        m.done = 1;
        push(6, m, 1'b1, r, op, fn);
      end
      in_idle = !r;
    end else if (op == 6'h08) begin
      c.srca = 1; c.srcb = 2'b10; c.aluop = 3'b010;
      push(9, c, 1'($urandom), r, op, fn);
      c = '0; c.rgw = 1; c.done = 1;
      push(10, c, 1'($urandom), r, op, fn);
      in_idle = !r;
    end else if (op == 6'h04) begin
      c.srca = 1; c.aluop = 3'b110; c.pcwc = 1;
      c.pcs = 2'b01; c.done = 1;
      push(11, c, 1'($urandom), r, op, fn);
      in_idle = !r;
    end else if (op == 6'h02) begin
      c.pcw = 1; c.pcs = 2'b10; c.done = 1;
      push(12, c, 1'($urandom), r, op, fn);
      in_idle = !r;
    end else begin
      c.ill = 1;
      push(13, c, 1'($urandom), r, op, fn);
      in_idle = 1'b1;
    end
  endtask

  // Apply and check up to n queued steps; called at a negedge.
  task automatic drain(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      run = s.rn; mem_ready = s.mr;
      opcode = s.op; funct = s.fn;
      #1;
      step_no++;
      check($sformatf("state@%0d", step_no), 32'(state_out),
            32'(s.st));
      check($sformatf("ctl@%0d st%0d", step_no, s.st),
            32'(obs_c), 32'(s.c));
      @(negedge clk);
    end
  endtask

  initial begin
    logic [5:0] fl[7];
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    int         wf;
    int         wm;
    fl = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h22, 6'h2A};
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0;
    opcode = '0; funct = '0;
    #1;
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_ctl", 32'(obs_c), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    in_idle = 1'b1;

    gen(6'h00, 6'h22, 0, 0, 1'b1);
    gen(6'h23, 6'h00, 0, 3, 1'b1);
    gen(6'h2B, 6'h00, 0, TMO, 1'b1);
    gen(6'h2B, 6'h00, 0, TMO - 1, 1'b1);
    gen(6'h02, 6'h00, TMO, 0, 1'b1);
    gen(6'h23, 6'h00, TMO - 1, 0, 1'b1);
    gen(6'h3F, 6'h00, 0, 0, 1'b1);
    gen(6'h00, 6'h08, 0, 0, 1'b1);
    gen(6'h08, 6'h11, 1, 0, 1'b1);
    gen(6'h04, 6'h00, 0, 0, 1'b0);
    idle(3);
    gen(6'h02, 6'h00, 0, 0, 1'b1);
    drain(q.size());

    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: op = 6'h00;
        1: op = 6'h23;
        2: op = 6'h2B;
        3: op = 6'h08;
        4: op = 6'h04;
        5: op = 6'h02;
        6: op = 6'($urandom);
        default: op = 6'h00;
      endcase
      fn = ($urandom_range(0, 3) != 0) ? fl[$urandom_range(0, 6)]
                                       : 6'($urandom);
      wf = ($urandom_range(0, 24) == 0) ? TMO + $urandom_range(0, 1)
                                        : $urandom_range(0, 3);
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 1, TMO)
                                       : $urandom_range(0, 4);
      gen(op, fn, wf, wm, 1'($urandom_range(0, 3) != 0));
      if (in_idle && $urandom_range(0, 1) == 1)
        idle($urandom_range(1, 2));
    end
    drain(q.size());

    // Abandon an LW in its data wait with an asynchronous reset.
    if (!in_idle) begin
      gen(6'h08, 6'h00, 0, 0, 1'b0);
      drain(q.size());
    end
    idle(1);
    gen(6'h23, 6'h00, 0, 8, 1'b1);
    drain(6);
    check("pre_reset_memrd", 32'(state_out), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_state", 32'(state_out), 32'd0);
    check("async_reset_ctl", 32'(obs_c), 32'd0);
    q.delete();
    in_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    gen(6'h00, 6'h2A, 1, 0, 1'b0);
    drain(q.size());

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
